ncpu32k_ram_port_arb: RTL and testbench
=======================================

# ncpu32k_ram_port_arb

Two-requester round-robin arbiter and initial-clear sequencer for one port of the byte-writable true dual-port RAM cell. Sits between two bus masters (typically instruction fetch and data access) and a single RAM port; after reset it zero-fills the whole array, then grants one request per cycle and returns read-first data one cycle later.

## Interface
Parameters:
- AW, 10, RAM address width; array depth is 2^AW words.
- DW, 32, data width; must be a multiple of 8.
- CLEAR_ON_RESET, 1, 1: zero-fill the array after reset; 0: enter SERVE directly.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mN_valid  in  1  (N=0,1) request present.
- mN_ready  out  1  request accepted this cycle when high with mN_valid.
- mN_addr  in  AW  word address.
- mN_we  in  DW/8  byte write enables; all-zero means read.
- mN_wdata  in  DW  write data.
- mN_rsp_valid  out  1  response for requester N this cycle (no backpressure).
- mN_rdata  out  DW  read-first data (old word contents), valid with mN_rsp_valid.
- ram_en  out  1  RAM port enable.
- ram_addr  out  AW  RAM port address.
- ram_we  out  DW/8  RAM byte enables.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data.

## Operation
- States: CLEAR, SERVE. Reset enters CLEAR if CLEAR_ON_RESET else SERVE.
- CLEAR: clr_cnt (AW bits) starts at 0; each cycle ram_en=1, ram_addr=clr_cnt, ram_we=all ones, ram_din=0; clr_cnt increments. When clr_cnt == 2^AW-1 is written, next state SERVE. m0_ready=m1_ready=0 throughout.
- SERVE: arbitration combinational on current mN_valid.
  - Only one valid: grant it.
  - Both valid: grant the requester not granted most recently (last_gnt register); last_gnt resets to 1 so m0 wins the first tie.
  - last_gnt updates only on a grant.
  - Granted mN_ready=1; the other 0. mN_ready is 0 when no request (no ready-before-valid).
  - RAM port driven combinationally from granted requester: ram_en=1, addr/we/din forwarded. No grant: ram_en=0, ram_we=0, addr/din don't-care (drive 0).
- Response: registered rsp_id/rsp_pending; cycle after a grant, mN_rsp_valid=1 for the granted N, mN_rdata=ram_dout. Writes also produce a response (ack) carrying the pre-write word.
- mN_rdata driven from ram_dout to both requesters; only meaningful with rsp_valid.
- Requesters must hold addr/we/wdata stable while valid && !ready.

## Timing
- Reset values: state per CLEAR_ON_RESET, clr_cnt=0, last_gnt=1, mN_ready=0, mN_rsp_valid=0, ram_en=1 in CLEAR (0 if CLEAR_ON_RESET=0), ram_we=all ones in CLEAR.
- Clear duration: exactly 2^AW cycles after rst_n deasserts; first SERVE grant possible in cycle 2^AW.
- Read/write latency: accept in cycle T, rsp_valid in T+1. Throughput one request per cycle, sustained.
- Simultaneous: same-address back-to-back (write T, read T+1) returns new data, since RAM write lands at T edge.
- Reset mid-CLEAR or mid-response: async, drops pending response, restarts clear from address 0.
- clr_cnt wrap is not reached; transition on terminal count.

## Structure
- Shared header: state encodings (ST_CLEAR, ST_SERVE).
- Sub-module ncpu32k_rr_arb2: 2-input round-robin arbiter (req[1:0], last_gnt register, gnt one-hot); reusable for other shared resources.
- Top holds clear counter, state register, RAM mux, response register.

## Test plan
All with AW=4, DW=32, RAM cell attached, CLEAR_ON_RESET=1 unless noted.
- Release reset, preload RAM with 0xFFFFFFFF -> ready stays 0 for 16 cycles, ram_we=4'hF on addresses 0..15 in order; readback of all 16 words = 0.
- m0 write addr 3, we=4'hF, data 0xDEADBEEF; then m0 read addr 3 -> first rsp rdata=0x00000000, second rsp rdata=0xDEADBEEF, each one cycle after accept.
- m1 write addr 3 we=4'b0010 data 0x0000AB00 after previous -> subsequent read returns 0xDEADABEF.
- m0 and m1 both valid for 6 cycles -> grants 0,1,0,1,0,1; rsp_valid alternates m0/m1 one cycle behind.
- Assert rst_n low at clear cycle 5 for 2 cycles -> clr_cnt restarts at 0, ready rises exactly 16 cycles after release, no rsp_valid emitted.
- CLEAR_ON_RESET=0: m1 read addr 0 in first cycle after reset -> m1_ready=1 immediately, m1_rsp_valid next cycle.

Source files
------------

// File: rtl/ncpu32k_ram_port_arb_pkg.sv
// Shared definitions for the RAM port arbiter: controller states and the
// two-way round-robin pick used by the arbiter sub-module.
package ncpu32k_ram_port_arb_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  localparam int NUM_REQ = 2;

  // lastGnt is the index of the most recently granted requester.
  // A tie goes to the other requester.
  function automatic logic [1:0] rrPick(input logic [1:0] req, input logic lastGnt);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = lastGnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/ncpu32k_rr_arb2.sv
// Two-input round-robin arbiter with one-hot grant.
// The grant is combinational on req_i; the history advances only when something is granted.
module ncpu32k_rr_arb2
  import ncpu32k_ram_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic lastGnt_q;
  logic lastGnt_d;

  // Reset history to requester 1 so requester 0 wins the first tie.
  always_comb begin
    gnt_o     = rrPick(req_i, lastGnt_q);
    lastGnt_d = lastGnt_q;
    if (|gnt_o) begin
      lastGnt_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGnt_q <= 1'b1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule

// File: rtl/ncpu32k_ram_port_arb.sv
// One RAM port shared by two requesters: zero-fills the array after reset,
// then grants one request per cycle and returns read-first data a cycle later.
module ncpu32k_ram_port_arb
  import ncpu32k_ram_port_arb_pkg::*;
#(
  parameter int AW             = 10,
  parameter int DW             = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW/8-1:0] m0_we,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_rsp_valid,
  output logic [DW-1:0]   m0_rdata,

  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW/8-1:0] m1_we,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_rsp_valid,
  output logic [DW-1:0]   m1_rdata,

  output logic            ram_en,
  output logic [AW-1:0]   ram_addr,
  output logic [DW/8-1:0] ram_we,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;

  state_e        state_q, state_d;
  logic [AW-1:0] clrCnt_q, clrCnt_d;
  logic          rspPending_q, rspPending_d;
  logic          rspId_q, rspId_d;
  logic [1:0]    req;
  logic [1:0]    gnt;

  // Requests are masked off entirely while the array is being cleared.
  always_comb begin
    req = 2'b00;
    if (state_q == ST_SERVE) begin
      req = {m1_valid, m0_valid};
    end
  end

  ncpu32k_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    ram_en   = 1'b0;
    ram_addr = '0;
    ram_we   = '0;
    ram_din  = '0;
    case (state_q)
      ST_CLEAR: begin
        ram_en   = 1'b1;
        ram_addr = clrCnt_q;
        ram_we   = '1;
        clrCnt_d = clrCnt_q + 1'b1;
        if (clrCnt_q == {AW{1'b1}}) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (gnt[0]) begin
          ram_en   = 1'b1;
          ram_addr = m0_addr;
          ram_we   = m0_we;
          ram_din  = m0_wdata;
        end else if (gnt[1]) begin
          ram_en   = 1'b1;
          ram_addr = m1_addr;
          ram_we   = m1_we;
          ram_din  = m1_wdata;
        end
      end
      default: begin
        state_d = RST_STATE;
      end
    endcase
  end

  // Every grant, read or write, earns exactly one response on the next cycle.
  always_comb begin
    rspPending_d = |gnt;
    rspId_d      = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      clrCnt_q     <= '0;
      rspPending_q <= 1'b0;
      rspId_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clrCnt_q     <= clrCnt_d;
      rspPending_q <= rspPending_d;
      rspId_q      <= rspId_d;
    end
  end

  assign m0_ready     = gnt[0];
  assign m1_ready     = gnt[1];
  assign m0_rsp_valid = rspPending_q && !rspId_q;
  assign m1_rsp_valid = rspPending_q && rspId_q;
  assign m0_rdata     = ram_dout;
  assign m1_rdata     = ram_dout;

endmodule

// File: tb/tb_ncpu32k_ram_port_arb.sv
// Directed bench for the RAM port arbiter: clear sequence, read-first responses,
// byte writes, round-robin ties, reset during clear, and the no-clear variant.
module tb_ncpu32k_ram_port_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b0;

  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [3:0]  m0_addr = '0, m1_addr = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        b_m1_valid = 1'b0;
  logic [3:0]  b_m1_addr = '0;
  logic        b_m0_ready, b_m1_ready, b_m0_rsp_valid, b_m1_rsp_valid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_ram_en;
  logic [3:0]  b_ram_addr, b_ram_we;
  logic [31:0] b_ram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ncpu32k_ram_port_arb #(.AW(4), .DW(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  ncpu32k_ram_port_arb #(.AW(4), .DW(32), .CLEAR_ON_RESET(1'b0)) dut_noclr (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(1'b0), .m0_ready(b_m0_ready), .m0_addr(4'h0), .m0_we(4'h0),
    .m0_wdata(32'h0), .m0_rsp_valid(b_m0_rsp_valid), .m0_rdata(b_m0_rdata),
    .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_addr(b_m1_addr), .m1_we(4'h0),
    .m1_wdata(32'h0), .m1_rsp_valid(b_m1_rsp_valid), .m1_rdata(b_m1_rdata),
    .ram_en(b_ram_en), .ram_addr(b_ram_addr), .ram_we(b_ram_we), .ram_din(b_ram_din),
    .ram_dout(32'hA5A5_0001)
  );

  // Read-first byte-writable RAM with registered output.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic [3:0] addr,
                               input logic [3:0] we, input logic [31:0] data);
    if (port == 0) begin
      m0_valid = valid; m0_addr = addr; m0_we = we; m0_wdata = data;
    end else begin
      m1_valid = valid; m1_addr = addr; m1_we = we; m1_wdata = data;
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    $display("[TB] starting ncpu32k_ram_port_arb bench");

    // Reset with preload of all ones, request held during clear.
    applyStimulus(0, 1'b1, 4'h0, 4'h0, 32'h0);
    rst_n = 1'b0;
    preload = 1'b1;
    stepClk();
    checkOutput("rst_m0_ready", m0_ready, 0);
    checkOutput("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("rst_ram_en", ram_en, 1);
    checkOutput("rst_ram_we", ram_we, 4'hF);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_noclr_ram_en", b_ram_en, 0);
    stepClk();
    preload = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("clr_addr_%0d", i), ram_addr, i);
      checkOutput($sformatf("clr_we_%0d", i), ram_we, 4'hF);
      checkOutput($sformatf("clr_din_%0d", i), ram_din, 0);
      checkOutput($sformatf("clr_ready_%0d", i), {m0_ready, m1_ready}, 0);
      stepClk();
    end

    // Pipelined readback of the whole array.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) applyStimulus(0, 1'b1, 4'(i), 4'h0, 32'h0);
      else applyStimulus(0, 1'b0, 4'h0, 4'h0, 32'h0);
      @(negedge clk);
      if (i < 16) checkOutput($sformatf("rb_ready_%0d", i), m0_ready, 1);
      if (i > 0) begin
        checkOutput($sformatf("rb_rspv_%0d", i - 1), m0_rsp_valid, 1);
        checkOutput($sformatf("rb_data_%0d", i - 1), m0_rdata, 32'h0);
      end
      stepClk();
    end
    @(negedge clk);
    checkOutput("idle_ram_en", ram_en, 0);
    checkOutput("idle_ram_we", ram_we, 0);
    checkOutput("idle_rspv", {m0_rsp_valid, m1_rsp_valid}, 0);
    stepClk();

    // m0 write then read, m1 byte write then read, all on address 3.
    applyStimulus(0, 1'b1, 4'h3, 4'hF, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("w0_ready", m0_ready, 1);
    checkOutput("w0_ram_din", ram_din, 32'hDEAD_BEEF);
    stepClk();
    applyStimulus(0, 1'b1, 4'h3, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("r0_ready", m0_ready, 1);
    checkOutput("w0_rspv", {m1_rsp_valid, m0_rsp_valid}, 2'b01);
    checkOutput("w0_rdata", m0_rdata, 32'h0);
    stepClk();
    applyStimulus(0, 1'b0, 4'h0, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 4'h3, 4'b0010, 32'h0000_AB00);
    @(negedge clk);
    checkOutput("w1_ready", {m1_ready, m0_ready}, 2'b10);
    checkOutput("r0_rspv", m0_rsp_valid, 1);
    checkOutput("r0_rdata", m0_rdata, 32'hDEAD_BEEF);
    stepClk();
    applyStimulus(1, 1'b1, 4'h3, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("w1_rspv", {m1_rsp_valid, m0_rsp_valid}, 2'b10);
    checkOutput("w1_rdata", m1_rdata, 32'hDEAD_BEEF);
    stepClk();
    applyStimulus(1, 1'b0, 4'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("r1_rspv", m1_rsp_valid, 1);
    checkOutput("r1_rdata", m1_rdata, 32'hDEAD_ABEF);
    stepClk();

    // Both valid for six cycles: m0 reads 3, m1 reads 5.
    applyStimulus(0, 1'b1, 4'h3, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 4'h5, 4'h0, 32'h0);
    for (int i = 0; i <= 6; i++) begin
      if (i == 6) begin
        applyStimulus(0, 1'b0, 4'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 4'h0, 4'h0, 32'h0);
      end
      @(negedge clk);
      if (i < 6)
        checkOutput($sformatf("tie_gnt_%0d", i), {m1_ready, m0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        checkOutput($sformatf("tie_rspv_%0d", i - 1), {m1_rsp_valid, m0_rsp_valid},
                    ((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
        if ((i - 1) % 2 == 0) checkOutput($sformatf("tie_rd0_%0d", i - 1), m0_rdata, 32'hDEAD_ABEF);
        else checkOutput($sformatf("tie_rd1_%0d", i - 1), m1_rdata, 32'h0);
      end
      stepClk();
    end

    // Reset while a response is pending drops it.
    applyStimulus(0, 1'b1, 4'h3, 4'h0, 32'h0);
    stepClk();
    applyStimulus(0, 1'b0, 4'h0, 4'h0, 32'h0);
    checkOutput("pend_rspv_before", m0_rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("pend_rspv_dropped", {m0_rsp_valid, m1_rsp_valid}, 0);
    checkOutput("pend_ram_addr", ram_addr, 0);
    stepClk();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) stepClk();
    checkOutput("midclr_addr5", ram_addr, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("midclr_addr_restart", ram_addr, 0);
    @(posedge clk);
    stepClk();
    rst_n = 1'b1;
    applyStimulus(0, 1'b1, 4'h2, 4'h0, 32'h0);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (n == 0) checkOutput("midclr_addr_rel", ram_addr, 0);
      if (m0_rsp_valid || m1_rsp_valid) checkOutput("midclr_no_rsp", 1, 0);
      if (m0_ready) break;
      n++;
      stepClk();
    end
    checkOutput("midclr_ready_cycle", n, 16);
    stepClk();
    applyStimulus(0, 1'b0, 4'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("midclr_rspv", m0_rsp_valid, 1);
    checkOutput("midclr_rdata", m0_rdata, 32'h0);
    stepClk();

    // No-clear instance: served in the first cycle after reset.
    rst_n = 1'b0;
    stepClk();
    rst_n = 1'b1;
    b_m1_valid = 1'b1;
    b_m1_addr = 4'h0;
    @(negedge clk);
    checkOutput("noclr_gnt", {b_m1_ready, b_m0_ready}, 2'b10);
    checkOutput("noclr_ram_en", b_ram_en, 1);
    checkOutput("noclr_ram_we", b_ram_we, 0);
    stepClk();
    b_m1_valid = 1'b0;
    @(negedge clk);
    checkOutput("noclr_rspv", {b_m1_rsp_valid, b_m0_rsp_valid}, 2'b10);
    checkOutput("noclr_rdata", b_m1_rdata, 32'hA5A5_0001);
    stepClk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
